// File: rtl/switch_event_collector_pkg.sv
// Shared types and default constants for the switch event collector.
package sw_evt_pkg;

  typedef enum logic [1:0] {
    PRIME  = 2'd0,
    IDLE   = 2'd1,
    SETTLE = 2'd2,
    PUSH   = 2'd3
  } sw_evt_state_t;

  localparam int unsigned SETTLE_CYC_DEFAULT = 32'd25000;
  localparam int unsigned QDEPTH_DEFAULT     = 32'd4;

endpackage

// File: rtl/switch_event_collector_if.sv
// Event handshake bundle between the collector (master) and the
// matrix-entry consumer (slave).
interface switch_event_collector_if #(
  parameter int unsigned WIDTH = 8
);
  logic             evt_valid;
  logic             evt_ready;
  logic [WIDTH-1:0] evt_value;
  logic [WIDTH-1:0] evt_mask;
  logic             evt_dropped;
  logic             drop_clr;

  modport master (
    output evt_valid, evt_value, evt_mask, evt_dropped,
    input  evt_ready, drop_clr
  );

  modport slave (
    input  evt_valid, evt_value, evt_mask, evt_dropped,
    output evt_ready, drop_clr
  );
endinterface

// File: rtl/switch_event_collector_fifo.sv
// Generic synchronous FIFO. A push into a full FIFO is accepted only when
// a pop happens in the same cycle. DEPTH must be a power of two.
module sw_evt_fifo #(
  parameter int unsigned W     = 16,
  parameter int unsigned DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         empty,
  output logic         full
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [W-1:0]  mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  logic          do_push_s;
  logic          do_pop_s;

  assign empty     = (count_r == CW'(0));
  assign full      = (count_r == CW'(DEPTH));
  assign do_pop_s  = pop && !empty;
  assign do_push_s = push && (!full || do_pop_s);
  assign dout      = mem_r[rd_ptr_r];

  // Storage, pointers and occupancy count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_r[i] <= '0;
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (do_push_s) begin
        mem_r[wr_ptr_r] <= din;
        wr_ptr_r        <= wr_ptr_r + AW'(1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end
endmodule

// File: rtl/switch_event_collector.sv
// Turns the debounced switch vector into settled, handshaked change events
// carrying the new switch word and a mask of changed bits.
// Build option: define SW_EVT_QUEUE_EN for a QDEPTH-entry event FIFO;
// otherwise a single holding register buffers one event.
module switch_event_collector
  import sw_evt_pkg::*;
#(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned SETTLE_CYC = SETTLE_CYC_DEFAULT,
  parameter int unsigned QDEPTH     = QDEPTH_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WIDTH-1:0]         sw_in,
  switch_event_collector_if.master evt
);
  localparam int unsigned CNTW = $clog2(SETTLE_CYC);
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(SETTLE_CYC - 1);

  sw_evt_state_t    state_r, state_nx_s;
  logic [WIDTH-1:0] sw_r, base_r, prev_r;
  logic [CNTW-1:0]  cnt_r;
  logic [WIDTH-1:0] mask_s;
  logic             push_s, pop_s, full_s, drop_s, valid_s, dropped_r;
  logic [WIDTH-1:0] head_value_s, head_mask_s;

  // Input capture; runs through reset so PRIME baselines the live switches.
  always_ff @(posedge clk) begin
    sw_r <= sw_in;
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_r <= PRIME;
    else     state_r <= state_nx_s;
  end

  // Next-state and push decision.
  always_comb begin
    state_nx_s = state_r;
    push_s     = 1'b0;
    mask_s     = sw_r ^ base_r;
    case (state_r)
      PRIME:  state_nx_s = IDLE;
      IDLE: begin
        if (sw_r != base_r) state_nx_s = SETTLE;
        else                state_nx_s = IDLE;
      end
      SETTLE: begin
        if (sw_r != prev_r)        state_nx_s = SETTLE;
        else if (cnt_r == CNT_LAST) state_nx_s = PUSH;
        else                        state_nx_s = SETTLE;
      end
      PUSH: begin
        state_nx_s = IDLE;
        push_s     = (mask_s != '0);
      end
      default: state_nx_s = PRIME;
    endcase
  end

  // Baseline, settle reference and quiet-cycle counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      base_r <= '0;
      prev_r <= '0;
      cnt_r  <= '0;
    end else begin
      case (state_r)
        PRIME: base_r <= sw_r;
        IDLE: begin
          if (sw_r != base_r) begin
            prev_r <= sw_r;
            cnt_r  <= '0;
          end
        end
        SETTLE: begin
          if (sw_r != prev_r) begin
            prev_r <= sw_r;
            cnt_r  <= '0;
          end else if (cnt_r != CNT_LAST) begin
            cnt_r <= cnt_r + CNTW'(1);
          end
        end
        PUSH:    base_r <= sw_r;
        default: base_r <= base_r;
      endcase
    end
  end

  assign pop_s  = valid_s && evt.evt_ready;
  assign drop_s = push_s && full_s && !pop_s;

`ifdef SW_EVT_QUEUE_EN
  logic empty_s;
  logic [2*WIDTH-1:0] dout_s;

  sw_evt_fifo #(.W(2 * WIDTH), .DEPTH(QDEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_s),
    .pop   (pop_s),
    .din   ({sw_r, mask_s}),
    .dout  (dout_s),
    .empty (empty_s),
    .full  (full_s)
  );

  assign valid_s                     = !empty_s;
  assign {head_value_s, head_mask_s} = dout_s;
`else
  logic               hold_valid_r;
  logic [2*WIDTH-1:0] hold_data_r;

  // Single-entry holding register; refills in the same cycle it is popped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_valid_r <= 1'b0;
      hold_data_r  <= '0;
    end else if (push_s && (!hold_valid_r || pop_s)) begin
      hold_valid_r <= 1'b1;
      hold_data_r  <= {sw_r, mask_s};
    end else if (pop_s) begin
      hold_valid_r <= 1'b0;
    end
  end

  assign full_s                      = hold_valid_r;
  assign valid_s                     = hold_valid_r;
  assign {head_value_s, head_mask_s} = hold_data_r;
`endif

  // Sticky drop flag; a new drop outranks a simultaneous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)               dropped_r <= 1'b0;
    else if (drop_s)       dropped_r <= 1'b1;
    else if (evt.drop_clr) dropped_r <= 1'b0;
  end

  assign evt.evt_valid   = valid_s;
  assign evt.evt_value   = head_value_s;
  assign evt.evt_mask    = head_mask_s;
  assign evt.evt_dropped = dropped_r;
endmodule

// File: tb/tb_switch_event_collector.sv
// Randomized and directed bench for switch_event_collector, checked every
// cycle against a deadline-based behavioural model with an event queue.
module tb_switch_event_collector;
  localparam int W  = 8;
  localparam int S  = 4;
  localparam int QD = 4;
`ifdef SW_EVT_QUEUE_EN
  localparam int CAP = QD;
`else
  localparam int CAP = 1;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] sw_in;

  switch_event_collector_if #(.WIDTH(W)) bus ();

  switch_event_collector #(.WIDTH(W), .SETTLE_CYC(S), .QDEPTH(QD)) dut (
    .clk   (clk),
    .rst   (rst),
    .sw_in (sw_in),
    .evt   (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed 'h%0h expected 'h%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Behavioural model: phase 0 = baseline pending, 1 = watching, 2 = waiting
  // for the settle deadline (an edge number) to be reached without change.
  logic [15:0]  mq[$];
  logic [W-1:0] m_sw, m_base, m_prev;
  int           m_phase;
  longint       cyc = 0;
  longint       deadline;
  bit           m_drop;

  task automatic model_reset();
    mq.delete();
    m_phase = 0;
    m_drop  = 1'b0;
    m_base  = '0;
  endtask

  task automatic model_edge();
    bit           pop, accept, dropnow;
    logic [W-1:0] mask;
    cyc++;
    if (rst) begin
      model_reset();
      m_sw = sw_in;
      return;
    end
    pop = (mq.size() != 0) && bus.evt_ready;
    accept = 1'b0;
    dropnow = 1'b0;
    mask = '0;
    case (m_phase)
      0: begin m_base = m_sw; m_phase = 1; end
      1: if (m_sw != m_base) begin
           m_prev = m_sw; deadline = cyc + S + 1; m_phase = 2;
         end
      default: begin
        if (cyc == deadline) begin
          mask = m_sw ^ m_base;
          m_base = m_sw;
          m_phase = 1;
          if (mask != 0) begin
            if (mq.size() < CAP || pop) accept = 1'b1;
            else dropnow = 1'b1;
          end
        end else if (m_sw != m_prev) begin
          m_prev = m_sw; deadline = cyc + S + 1;
        end
      end
    endcase
    if (pop) void'(mq.pop_front());
    if (accept) mq.push_back({m_sw, mask});
    if (dropnow) m_drop = 1'b1;
    else if (bus.drop_clr) m_drop = 1'b0;
    m_sw = sw_in;
  endtask

  task automatic compare_all();
    check_eq("evt_valid", 32'(bus.evt_valid), 32'(mq.size() != 0));
    if (mq.size() != 0) begin
      check_eq("evt_value", 32'(bus.evt_value), 32'(mq[0][15:8]));
      check_eq("evt_mask",  32'(bus.evt_mask),  32'(mq[0][7:0]));
    end
    check_eq("evt_dropped", 32'(bus.evt_dropped), 32'(m_drop));
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all();
  endtask

  task automatic hold(input int n);
    repeat (n) tick();
  endtask

  task automatic check_zero_outputs(input string tag);
    check_eq({tag, "_valid"},   32'(bus.evt_valid),   32'd0);
    check_eq({tag, "_value"},   32'(bus.evt_value),   32'd0);
    check_eq({tag, "_mask"},    32'(bus.evt_mask),    32'd0);
    check_eq({tag, "_dropped"}, 32'(bus.evt_dropped), 32'd0);
  endtask

  // Called at a negedge: assert reset asynchronously and check outputs clear.
  task automatic async_reset(input string tag);
    rst = 1'b1;
    model_reset();
    #1;
    check_zero_outputs(tag);
  endtask

  task automatic pulse_ready();
    bus.evt_ready = 1'b1;
    tick();
    bus.evt_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    sw_in = 8'hA5;
    bus.evt_ready = 1'b0;
    bus.drop_clr = 1'b0;
    model_reset();
    m_sw = sw_in;
    @(negedge clk);
    #1;
    check_zero_outputs("reset");
    hold(3);
    rst = 1'b0;
    // Switches present at reset are never reported.
    hold(20);
    check_eq("no_evt_after_reset", 32'(bus.evt_valid), 32'd0);

    // Move to a 00 baseline and drain the resulting event.
    sw_in = 8'h00;
    hold(10);
    pulse_ready();
    hold(2);

    // Single edit 00 -> 03.
    sw_in = 8'h03;
    hold(8);
    check_eq("edit03_valid", 32'(bus.evt_valid), 32'd1);
    pulse_ready();
    hold(1);
    sw_in = 8'h00;
    hold(10);
    pulse_ready();
    hold(2);

    // Staggered two-bit edit -> single event 11 / 11.
    sw_in = 8'h01;
    hold(2);
    sw_in = 8'h11;
    hold(10);
    pulse_ready();
    hold(2);

    // Flip and restore bit2 quickly -> no event.
    sw_in = 8'h15;
    hold(2);
    sw_in = 8'h11;
    hold(12);

    // Five distinct edits without consumer: overflow and drop.
    for (int i = 0; i < 5; i++) begin
      sw_in = sw_in ^ (8'h20 << (i % 3));
      hold(8);
    end
    check_eq("overflow_dropped", 32'(bus.evt_dropped), 32'd1);
    bus.drop_clr = 1'b1;
    tick();
    bus.drop_clr = 1'b0;
    hold(1);
    bus.evt_ready = 1'b1;
    hold(6);
    bus.evt_ready = 1'b0;

    // Two queued events, then reset in the middle of a settle window.
    sw_in = 8'h3C; hold(8);
    sw_in = 8'h3D; hold(8);
    sw_in = 8'hC3; hold(2);
    async_reset("mid_settle_reset");
    hold(2);
    rst = 1'b0;
    hold(15);
    check_eq("no_evt_after_rerst", 32'(bus.evt_valid), 32'd0);

    // Randomized traffic with varying consumer speed.
    for (int seg = 0; seg < 15; seg++) begin
      int ready_pct = $urandom_range(0, 100);
      for (int c = 0; c < 200; c++) begin
        if ($urandom_range(0, 9) == 0) sw_in = sw_in ^ (8'h01 << $urandom_range(0, 7));
        if ($urandom_range(0, 29) == 0) sw_in = 8'($urandom);
        bus.evt_ready = ($urandom_range(0, 99) < ready_pct);
        bus.drop_clr  = ($urandom_range(0, 39) == 0);
        if ($urandom_range(0, 1499) == 0) begin
          async_reset("rand_reset");
          tick();
          rst = 1'b0;
        end
        tick();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/switch_event_collector.md
# switch_event_collector

Converts the debounced slide-switch vector into discrete, handshaked change events for the matrix-entry control logic. Sits directly downstream of the switch debouncer bank. Waits for a multi-switch edit to settle, then reports the new switch word plus a mask of the bits that changed. Events are buffered so slow consumers do not lose edits.

## Interface
- `WIDTH`, 8: switch count; must match the debouncer bank width.
- `SETTLE_CYC`, 25000: quiet cycles required before an event is emitted (1 ms at 25 MHz); must be ≥2.
- `QDEPTH`, 4: event queue depth; power of two, ≥2; used only with `SW_EVT_QUEUE_EN`.
- `clk`, in, 1: single system clock.
- `rst`, in, 1: reset, asynchronous, active-high.
- `sw_in`, in, `WIDTH`: debounced switch levels.
- `evt_valid`, out, 1: head event available.
- `evt_ready`, in, 1: consumer accepts the head event.
- `evt_value`, out, `WIDTH`: switch word of the head event.
- `evt_mask`, out, `WIDTH`: bits that differ from the previous baseline.
- `evt_dropped`, out, 1: sticky flag, set when an event is lost because the queue was full.
- `drop_clr`, in, 1: single-cycle pulse that clears `evt_dropped`.

## Operation
- Input register: `sw_r <= sw_in` every cycle. All comparisons use `sw_r`.
- State machine states: PRIME, IDLE, SETTLE, PUSH. Reset state is PRIME.
- **PRIME:** `base <= sw_r`, go to IDLE. No event is generated, so the switch positions present at reset are never reported.
- **IDLE:** if `sw_r != base`, then `prev <= sw_r`, `cnt <= 0`, go to SETTLE.
- **SETTLE:** if `sw_r != prev`, then `prev <= sw_r` and `cnt <= 0`. Otherwise, if `cnt == SETTLE_CYC-1`, go to PUSH. Otherwise `cnt++`.
- **PUSH:**
  - Compute `mask = sw_r ^ base`.
  - If `mask == 0` (edit reverted), no event is produced.
  - Otherwise enqueue `{sw_r, mask}`.
  - `base <= sw_r` always.
  - Go to IDLE.
- Queue:
  - `evt_valid` is high whenever the queue is non-empty.
  - Head is popped on `evt_valid && evt_ready`.
  - `evt_value` and `evt_mask` are held stable while `evt_valid && !evt_ready`.
- Full queue on push:
  - Simultaneous pop: the push is accepted.
  - No pop: the event is discarded and `evt_dropped <= 1`.
  - `base` is still updated in both cases.
- `evt_dropped`: sticky; cleared by `drop_clr`. If a drop and `drop_clr` occur in the same cycle, the set wins.
- `evt_ready` while empty is ignored.

## Timing
- Reset values:
  - `evt_valid`=0, `evt_value`=0, `evt_mask`=0, `evt_dropped`=0.
  - Queue empty, `cnt`=0, `base`=0, state PRIME.
- Reset mid-operation flushes the queue and any in-progress SETTLE. PRIME re-baselines on the first cycle after deassert.
- Latency: take the edge at which `sw_r` captures a new stable value as edge 0.
  - IDLE→SETTLE at edge 1.
  - SETTLE→PUSH at edge `SETTLE_CYC+1`.
  - `evt_valid` high after edge `SETTLE_CYC+2`.
- Any `sw_r` change during SETTLE restarts the full `SETTLE_CYC` window.
- Pop and push may occur in the same cycle. Throughput is one pop per cycle.

## Configuration
- `SW_EVT_QUEUE_EN` defined: `QDEPTH`-entry synchronous FIFO with full/empty tracked by a `$clog2(QDEPTH)+1`-bit occupancy count.
- `SW_EVT_QUEUE_EN` undefined:
  - Single holding register; `QDEPTH` is ignored.
  - "Full" means the holding register is valid.
  - The same drop and simultaneous push/pop rules apply.

## Structure
- Package `sw_evt_pkg`:
  - `sw_evt_state_t` enum (PRIME, IDLE, SETTLE, PUSH).
  - Default `SETTLE_CYC` and `QDEPTH` constants.
- Sub-module `sw_evt_fifo`: generic width/depth synchronous FIFO, instantiated only under `SW_EVT_QUEUE_EN`.

## Test plan
All scenarios use WIDTH=8 and SETTLE_CYC=4.
- Reset with `sw_in`=8'hA5, hold 20 cycles → `evt_valid` stays 0.
- From baseline 8'h00, set `sw_in`=8'h03 → `evt_valid` after edge 6 (edge 0 = `sw_r` capture), value 8'h03, mask 8'h03. Pulse `evt_ready` → `evt_valid` 0 next cycle.
- Toggle bit0, then bit4 two cycles later, then hold → exactly one event, value 8'h11, mask 8'h11. Rise occurs 4+2 cycles after the bit4 capture.
- Flip bit2 and restore it within 2 cycles → no event; `base` unchanged.
- Queue enabled, QDEPTH=4, `evt_ready`=0: produce 5 distinct edits → `evt_valid`=1 with 4 queued events; 5th dropped; `evt_dropped`=1. Pulse `drop_clr` → `evt_dropped`=0. Drain: 4 events in order.
- Assert `rst` during SETTLE with 2 events queued → all outputs 0 immediately. After release, re-baseline; no event for current switches.
